booth_divider: RTL and testbench

- Sequential signed divider and inverse partner of the 8x8 Booth multiplier datapath.
- Takes a 2*DW-bit signed dividend (multiplier product width) and a DW-bit signed divisor.
- Returns a DW-bit quotient truncated toward zero, a DW-bit remainder, and status flags.
- Iterative restoring algorithm on magnitudes, one quotient bit per clock, start/done handshake to the control unit.

---
 rtl/booth_pkg.sv | 18 +
 rtl/booth_abs.sv | 20 ++
 rtl/booth_divider.sv | 171 +++++++++++++++++
 tb/tb_booth_divider.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier/divider datapath: operand widths,
// controller state encodings and the iteration-count rule.
package booth_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    // One quotient bit per dividend bit; the dividend is twice the operand width.
    function automatic int iter_count(input int dw);
        return 2 * dw;
    endfunction

endpackage

// File: rtl/booth_abs.sv
// Two's-complement conditional negate: yields |value| when negate is the sign bit,
// or restores a sign onto an unsigned magnitude.
module booth_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Negation of the most negative value wraps to 2^(W-1), read as unsigned.
    always_comb begin
        if (negate) begin
            result = ~value + {{(W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit
// per clock, with quotient saturation and divide-by-zero reporting.
module booth_divider
    import booth_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            overflow,
    output logic            div_by_zero
);

    localparam int ITERS = iter_count(DW);
    localparam int CW    = $clog2(ITERS);
    localparam logic [CW-1:0]   CNT_LAST = CW'(ITERS - 1);
    localparam logic [2*DW-1:0] QLIM_POS = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [2*DW-1:0] QLIM_NEG = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]   QSAT_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]   QSAT_NEG = {1'b1, {(DW-1){1'b0}}};

    div_state_t       state;
    logic [2*DW-1:0]  dvd_mag;
    logic [DW-1:0]    dvs_mag;
    logic             sign_q;
    logic             sign_r;
    logic             zero_div;
    logic [DW:0]      p;
    logic [2*DW-1:0]  qmag;
    logic [CW-1:0]    cnt;

    logic [2*DW-1:0]  dvd_abs;
    logic [DW-1:0]    dvs_abs;
    logic [DW-1:0]    q_signed;
    logic [DW-1:0]    r_signed;
    logic [DW:0]      shifted;
    logic [DW+1:0]    diff;
    logic             q_bit;
    logic [DW:0]      p_next;
    logic             ovf_calc;
    logic             unused_bits;

    booth_abs #(.W(2*DW)) u_abs_dividend (
        .value  (dividend),
        .negate (dividend[2*DW-1]),
        .result (dvd_abs)
    );

    booth_abs #(.W(DW)) u_abs_divisor (
        .value  (divisor),
        .negate (divisor[DW-1]),
        .result (dvs_abs)
    );

    booth_abs #(.W(DW)) u_sign_quotient (
        .value  (qmag[DW-1:0]),
        .negate (sign_q),
        .result (q_signed)
    );

    booth_abs #(.W(DW)) u_sign_remainder (
        .value  (p[DW-1:0]),
        .negate (sign_r),
        .result (r_signed)
    );

    // P stays below |divisor| <= 2^(DW-1), so the shifted value always fits DW+1 bits.
    always_comb begin
        shifted = {p[DW-1:0], dvd_mag[2*DW-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_mag};
        q_bit   = ~diff[DW+1];
        if (q_bit) begin
            p_next = diff[DW:0];
        end else begin
            p_next = shifted;
        end
    end

    // The negative range reaches one further than the positive range.
    always_comb begin
        if (sign_q) begin
            ovf_calc = (qmag > QLIM_NEG);
        end else begin
            ovf_calc = (qmag > QLIM_POS);
        end
    end

    assign unused_bits = p[DW];

    // Controller and datapath registers; outputs hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            dvd_mag     <= '0;
            dvs_mag     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            zero_div    <= 1'b0;
            p           <= '0;
            qmag        <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dvd_mag     <= dvd_abs;
                        dvs_mag     <= dvs_abs;
                        sign_q      <= dividend[2*DW-1] ^ divisor[DW-1];
                        sign_r      <= dividend[2*DW-1];
                        zero_div    <= (divisor == {DW{1'b0}});
                        p           <= '0;
                        qmag        <= '0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= (divisor == {DW{1'b0}}) ? ST_FIX : ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    p       <= p_next;
                    qmag    <= {qmag[2*DW-2:0], q_bit};
                    dvd_mag <= {dvd_mag[2*DW-2:0], 1'b0};
                    cnt     <= cnt + {{(CW-1){1'b0}}, 1'b1};
                    state   <= (cnt == CNT_LAST) ? ST_FIX : ST_CALC;
                end
                ST_FIX: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                    if (zero_div) begin
                        quotient    <= '0;
                        remainder   <= '0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        overflow    <= ovf_calc;
                        div_by_zero <= 1'b0;
                        remainder   <= r_signed;
                        if (ovf_calc) begin
                            quotient <= sign_q ? QSAT_NEG : QSAT_POS;
                        end else begin
                            quotient <= q_signed;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: directed operations push expected results,
// a negedge monitor compares them against each done pulse.
module tb_booth_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        overflow;
    logic        div_by_zero;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
        logic       dbz;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    booth_divider #(.DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            check("busy_done_exclusive", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_q"},   {24'd0, quotient},  {24'd0, e.q});
                check({e.name, "_r"},   {24'd0, remainder}, {24'd0, e.r});
                check({e.name, "_ovf"}, {31'd0, overflow},  {31'd0, e.ovf});
                check({e.name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
            end
        end
    end

    task automatic push_exp(input string name, input logic [7:0] q, input logic [7:0] r,
                            input logic ovf, input logic dbz);
        exp_t e;
        e.name = name;
        e.q    = q;
        e.r    = r;
        e.ovf  = ovf;
        e.dbz  = dbz;
        sb.push_back(e);
    endtask

    // Issue one operation, optionally pulse start with other operands mid-flight,
    // and check busy length and done latency.
    task automatic op(input string name, input int dvd, input int dvs,
                      input logic [7:0] q, input logic [7:0] r, input logic ovf,
                      input logic dbz, input int exp_lat, input int pulse_at);
        int nb;
        int lat;
        nb  = 0;
        lat = -1;
        @(negedge clk);
        dividend = dvd[15:0];
        divisor  = dvs[7:0];
        start    = 1'b1;
        push_exp(name, q, r, ovf, dbz);
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == pulse_at) begin
                start    = 1'b1;
                dividend = 16'd50;
                divisor  = 8'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
            if (busy) nb++;
        end
        start = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, nb, exp_lat);
    endtask

    initial begin
        int nd;
        int cyc;
        int last;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {20'd0, busy, done, quotient, remainder, overflow, div_by_zero},
              32'd0);
        @(negedge clk);
        rst = 1'b0;

        op("p100_d7",    100,    7,    8'h0E, 8'h02, 1'b0, 1'b0, 17, -1);
        op("m100_d7",    -100,   7,    8'hF2, 8'hFE, 1'b0, 1'b0, 17, -1);
        op("p100_dm7",   100,    -7,   8'hF2, 8'h02, 1'b0, 1'b0, 17, -1);
        op("p1000_d3",   1000,   3,    8'h7F, 8'h01, 1'b1, 1'b0, 17, -1);
        op("m1000_d3",   -1000,  3,    8'h80, 8'hFF, 1'b1, 1'b0, 17, -1);
        op("m384_d3",    -384,   3,    8'h80, 8'h00, 1'b0, 1'b0, 17, -1);
        op("m32768_dm128", -32768, -128, 8'h7F, 8'h00, 1'b1, 1'b0, 17, -1);
        op("p55_d0",     55,     0,    8'h00, 8'h00, 1'b0, 1'b1, 1,  -1);
        op("after_dbz",  100,    7,    8'h0E, 8'h02, 1'b0, 1'b0, 17, -1);
        op("start_in_calc", 100, 7,    8'h0E, 8'h02, 1'b0, 1'b0, 17, 3);

        // Start held high: back-to-back operations, one done every 18 cycles.
        @(negedge clk);
        dividend = 16'd200;
        divisor  = 8'd10;
        start    = 1'b1;
        for (int k = 0; k < 3; k++) push_exp("b2b_200_d10", 8'd20, 8'd0, 1'b0, 1'b0);
        nd   = 0;
        cyc  = 0;
        last = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                nd++;
                if (nd > 1) check("b2b_interval", cyc - last, 18);
                last = cyc;
                if (nd == 3) begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", nd, 3);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midop_reset_busy", {31'd0, busy}, 32'd0);
        check("midop_reset_outputs", {22'd0, done, quotient, remainder, overflow}, 32'd0);
        check("midop_reset_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("no_done_after_reset", nd, 0);

        op("p127_d1", 127, 1, 8'h7F, 8'h00, 1'b0, 1'b0, 17, -1);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
